// File: rtl/cook_ctrl_pkg.sv
// cook_ctrl_pkg: shared state encoding, time-step constants and preset table for cook_ctrl_param.
package cook_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COOK   = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int STEP_1S  = 1;
    localparam int STEP_10S = 10;
    localparam int STEP_1M  = 60;
    localparam int STEP_10M = 600;
    localparam int QUICK_S  = 30;

    // pwr = 0 in the table means "use the instance's DEF_PWR", which the package cannot know
    localparam logic [2:0] PWR_DEFAULT = 3'd0;

    typedef struct packed {
        logic [6:0] mins;
        logic [5:0] secs;
        logic [2:0] pwr;
    } preset_t;

    function automatic int step_secs(input logic [1:0] step);
        return step == 2'd0 ? STEP_1S :
               step == 2'd1 ? STEP_10S :
               step == 2'd2 ? STEP_1M : STEP_10M;
    endfunction

    function automatic preset_t preset_entry(input logic [2:0] idx);
        return idx == 3'd1 ? preset_t'{7'd99, 6'd30, 3'd1} :
               idx == 3'd2 ? preset_t'{7'd3,  6'd30, 3'd2} :
               idx == 3'd3 ? preset_t'{7'd1,  6'd15, 3'd3} :
                             preset_t'{7'd0,  6'd0,  PWR_DEFAULT};
    endfunction

endpackage

// File: rtl/cook_ctrl_param_tick.sv
// cook_tick_gen: seconds prescaler; counts while run_i, holds otherwise, clear_i wins.
module cook_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && cnt_q == CW'(TICK_DIV - 1);

    always_comb cnt_d = clear_i ? '0 : !run_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cook_ctrl_param.sv
// cook_ctrl_param: microwave controller (idle/cook/pause/done, time entry, power, presets).
// Optional quick start (+30 s on start) is enabled by defining COOK_CTRL_QUICK_START_EN.
module cook_ctrl_param
    import cook_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int MAX_MIN     = 99,
    parameter int N_PWR       = 3,
    parameter int DEF_PWR     = 2,
    parameter int NUM_PRESETS = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           pause,
    input  logic                           door,
    input  logic                           inc,
    input  logic                           dec,
    input  logic                           pwr_sel,
    input  logic [1:0]                     step,
    input  logic [2:0]                     preset,
    output logic [$clog2(MAX_MIN+1)-1:0]   min_o,
    output logic [5:0]                     sec_o,
    output logic [$clog2(N_PWR+1)-1:0]     pwr_o,
    output logic [N_PWR-1:0]               pwr_led,
    output logic [1:0]                     state_o,
    output logic                           done
);

    localparam int MW   = $clog2(MAX_MIN + 1);
    localparam int PW   = $clog2(N_PWR + 1);
    localparam int TMAX = MAX_MIN * 60 + 59;
    localparam int TW   = $clog2(TMAX + STEP_10M + 1);

    state_e          state_q, state_d;
    logic [MW-1:0]   min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic [PW-1:0]   pwr_q, pwr_d, pwr_up, pwr_dn, pwr_pre;
    logic [N_PWR-1:0] led_q, led_d;
    logic            done_q, done_d, door_q, tick, preset_ok;
    logic [TW-1:0]   t_cur, t_d, t_up, t_dn, t_pre, step_t;
    preset_t         pst;
    int              pt;

    cook_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .run_i   (state_q == ST_COOK && !door && !stop),
        .clear_i (state_q != ST_COOK && state_q != ST_PAUSED),
        .tick_o  (tick)
    );

    // Time is handled as total seconds so carry/borrow and saturation are exact
    assign t_cur     = TW'(min_q) * TW'(60) + TW'(sec_q);
    assign step_t    = TW'(step_secs(step));
    assign t_up      = (t_cur + step_t > TW'(TMAX)) ? TW'(TMAX) : t_cur + step_t;
    assign t_dn      = (t_cur > step_t) ? t_cur - step_t : '0;
    assign pwr_up    = (pwr_q == PW'(N_PWR)) ? pwr_q : pwr_q + PW'(1);
    assign pwr_dn    = (pwr_q == PW'(1)) ? pwr_q : pwr_q - PW'(1);
    assign preset_ok = preset != 3'd0 && int'(preset) <= NUM_PRESETS;

    always_comb begin
        pst     = preset_entry(preset);
        pt      = int'(pst.mins) * 60 + int'(pst.secs);
        t_pre   = (pt > TMAX) ? TW'(TMAX) : TW'(pt);
        pwr_pre = PW'(pst.pwr == PWR_DEFAULT ? DEF_PWR :
                      (int'(pst.pwr) > N_PWR ? N_PWR : int'(pst.pwr)));
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_cur;
        pwr_d   = pwr_q;
        if (stop) begin
            state_d = ST_IDLE;
            t_d     = '0;
            pwr_d   = PW'(DEF_PWR);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !door && t_cur != '0) state_d = ST_COOK;
`ifdef COOK_CTRL_QUICK_START_EN
                    else if (start && !door && !preset_ok) begin
                        state_d = ST_COOK;
                        t_d     = TW'(QUICK_S);
                    end
`endif
                    else if (preset_ok) begin
                        t_d   = t_pre;
                        pwr_d = pwr_pre;
                    end else if (inc) begin
                        t_d   = pwr_sel ? t_cur : t_up;
                        pwr_d = pwr_sel ? pwr_up : pwr_q;
                    end else if (dec) begin
                        t_d   = pwr_sel ? t_cur : t_dn;
                        pwr_d = pwr_sel ? pwr_dn : pwr_q;
                    end
                end
                ST_COOK: begin
                    if (door) state_d = ST_PAUSED;
                    else if (tick) begin
                        t_d     = t_cur - TW'(1);
                        state_d = (t_cur == TW'(1)) ? ST_DONE : ST_COOK;
                    end
`ifdef COOK_CTRL_QUICK_START_EN
                    else if (start) t_d = (t_cur + TW'(QUICK_S) > TW'(TMAX)) ? TW'(TMAX) : t_cur + TW'(QUICK_S);
`endif
                    else if (pause) state_d = ST_PAUSED;
                end
                ST_PAUSED: if (!door && (start || pause)) state_d = ST_COOK;
                default:   if (start || pause || inc || dec || (door && !door_q)) state_d = ST_IDLE;
            endcase
        end
        min_d  = MW'(t_d / 60);
        sec_d  = 6'(t_d % 60);
        done_d = state_d == ST_DONE && state_q != ST_DONE;
        led_d  = (state_q == ST_COOK) ? N_PWR'(1) << (pwr_q - PW'(1)) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            pwr_q   <= PW'(DEF_PWR);
            led_q   <= '0;
            done_q  <= 1'b0;
            door_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            pwr_q   <= pwr_d;
            led_q   <= led_d;
            done_q  <= done_d;
            door_q  <= door;
        end
    end

    assign min_o   = min_q;
    assign sec_o   = sec_q;
    assign pwr_o   = pwr_q;
    assign pwr_led = led_q;
    assign state_o = state_q;
    assign done    = done_q;

endmodule

// File: tb/tb_cook_ctrl_param.sv
// tb_cook_ctrl_param: directed scenarios plus randomized run against a total-seconds reference model.
module tb_cook_ctrl_param;

    localparam int TD = 4, MAXM = 99, NP = 3, DEFP = 2, NPRE = 3;
    localparam int TMAX = MAXM * 60 + 59;
    localparam int S_IDLE = 0, S_COOK = 1, S_PAUSED = 2, S_DONE = 3;
`ifdef COOK_CTRL_QUICK_START_EN
    localparam bit QS = 1'b1;
`else
    localparam bit QS = 1'b0;
`endif

    logic clock = 0, reset = 0, start = 0, stop = 0, pause = 0, door = 0, inc = 0, dec = 0, pwr_sel = 0;
    logic [1:0] step = 0;
    logic [2:0] preset = 0;
    logic [6:0] min_o;
    logic [5:0] sec_o;
    logic [1:0] pwr_o, state_o;
    logic [2:0] pwr_led;
    logic done;

    int total = 0, bad = 0;
    int m_st, m_t, m_pwr, m_ph, m_led;
    bit m_done, m_door_prev;
    int tab_m[8] = '{0, 99, 3, 1, 0, 0, 0, 0};
    int tab_s[8] = '{0, 30, 30, 15, 0, 0, 0, 0};
    int tab_p[8] = '{DEFP, 1, 2, 3, DEFP, DEFP, DEFP, DEFP};
    int stp[4]   = '{1, 10, 60, 600};

    cook_ctrl_param #(.TICK_DIV(TD), .MAX_MIN(MAXM), .N_PWR(NP), .DEF_PWR(DEFP), .NUM_PRESETS(NPRE)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause), .door(door),
        .inc(inc), .dec(dec), .pwr_sel(pwr_sel), .step(step), .preset(preset),
        .min_o(min_o), .sec_o(sec_o), .pwr_o(pwr_o), .pwr_led(pwr_led), .state_o(state_o), .done(done)
    );

    always #5 clock = ~clock;

    task automatic m_reset();
        m_st = S_IDLE; m_t = 0; m_pwr = DEFP; m_ph = 0; m_led = 0; m_done = 0; m_door_prev = 0;
    endtask

    // One clock of the controller, from the written rules, on total seconds
    task automatic m_step();
        int nst, nt, np, nph;
        bit pv, adv, tick;
        nst = m_st; nt = m_t; np = m_pwr;
        adv  = (m_st == S_COOK) && !door && !stop;
        tick = adv && (m_ph == TD - 1);
        nph  = (m_st == S_COOK || m_st == S_PAUSED) ? (adv ? (m_ph + 1) % TD : m_ph) : 0;
        pv   = preset >= 1 && preset <= NPRE;
        if (stop) begin
            nst = S_IDLE; nt = 0; np = DEFP;
        end else if (m_st == S_IDLE) begin
            if (start && !door && m_t > 0) nst = S_COOK;
            else if (QS && start && !door && !pv) begin nst = S_COOK; nt = 30; end
            else if (pv) begin nt = tab_m[preset] * 60 + tab_s[preset]; np = tab_p[preset]; end
            else if (inc) begin
                if (pwr_sel) np = (m_pwr + 1 > NP) ? NP : m_pwr + 1;
                else nt = (m_t + stp[step] > TMAX) ? TMAX : m_t + stp[step];
            end else if (dec) begin
                if (pwr_sel) np = (m_pwr - 1 < 1) ? 1 : m_pwr - 1;
                else nt = (m_t - stp[step] < 0) ? 0 : m_t - stp[step];
            end
        end else if (m_st == S_COOK) begin
            if (door) nst = S_PAUSED;
            else if (tick) begin nt = m_t - 1; if (nt == 0) nst = S_DONE; end
            else if (QS && start) nt = (m_t + 30 > TMAX) ? TMAX : m_t + 30;
            else if (pause) nst = S_PAUSED;
        end else if (m_st == S_PAUSED) begin
            if (!door && (start || pause)) nst = S_COOK;
        end else begin
            if (start || pause || inc || dec || (door && !m_door_prev)) nst = S_IDLE;
        end
        m_led = (m_st == S_COOK) ? (1 << (m_pwr - 1)) : 0;
        m_done = (nst == S_DONE) && (m_st != S_DONE);
        m_st = nst; m_t = nt; m_pwr = np; m_ph = nph; m_door_prev = door;
    endtask

    task automatic cyc();
        m_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        total++; if ({min_o, sec_o} !== 13'd0) begin bad++; $display("FAIL reset_time got=%0d:%0d exp=0:0", min_o, sec_o); end
        total++; if (pwr_o !== 2'd2) begin bad++; $display("FAIL reset_pwr got=%0d exp=2", pwr_o); end
        total++; if (pwr_led !== 3'd0) begin bad++; $display("FAIL reset_led got=%b exp=000", pwr_led); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 0;
    endtask

    task automatic test_manual();
        step = 1; inc = 1; repeat (6) cyc(); inc = 0;
        total++; if ({min_o, sec_o} !== {7'd1, 6'd0}) begin bad++; $display("FAIL manual_inc10s got=%0d:%0d exp=1:0", min_o, sec_o); end
        step = 0; dec = 1; cyc(); dec = 0;
        total++; if ({min_o, sec_o} !== {7'd0, 6'd59}) begin bad++; $display("FAIL manual_borrow got=%0d:%0d exp=0:59", min_o, sec_o); end
        step = 3; inc = 1; repeat (20) cyc(); inc = 0;
        total++; if ({min_o, sec_o} !== {7'd99, 6'd59}) begin bad++; $display("FAIL manual_sat got=%0d:%0d exp=99:59", min_o, sec_o); end
        stop = 1; cyc(); stop = 0;
        step = 2; dec = 1; cyc(); dec = 0;
        total++; if ({min_o, sec_o} !== 13'd0) begin bad++; $display("FAIL manual_floor got=%0d:%0d exp=0:0", min_o, sec_o); end
        step = 1; inc = 1; repeat (5) cyc(); step = 0; repeat (5) cyc(); step = 1; cyc(); inc = 0;
        total++; if ({min_o, sec_o} !== {7'd1, 6'd5}) begin bad++; $display("FAIL manual_carry got=%0d:%0d exp=1:5", min_o, sec_o); end
        pwr_sel = 1; inc = 1; repeat (3) cyc(); inc = 0;
        total++; if (pwr_o !== 2'd3) begin bad++; $display("FAIL pwr_sat_hi got=%0d exp=3", pwr_o); end
        dec = 1; repeat (4) cyc(); dec = 0;
        total++; if ({pwr_o, min_o, sec_o} !== {2'd1, 7'd1, 6'd5}) begin bad++; $display("FAIL pwr_sat_lo got=p%0d %0d:%0d exp=p1 1:5", pwr_o, min_o, sec_o); end
        pwr_sel = 0; stop = 1; cyc(); stop = 0;
        total++; if ({pwr_o, min_o, sec_o} !== {2'd2, 13'd0}) begin bad++; $display("FAIL manual_stop got=p%0d %0d:%0d exp=p2 0:0", pwr_o, min_o, sec_o); end
    endtask

    task automatic test_countdown();
        int pulses = 0;
        step = 0; inc = 1; repeat (2) cyc(); inc = 0;
        start = 1; cyc(); start = 0;
        total++; if ({state_o, min_o, sec_o} !== {2'd1, 7'd0, 6'd2}) begin bad++; $display("FAIL cd_start got=st%0d %0d:%0d exp=st1 0:2", state_o, min_o, sec_o); end
        repeat (3) begin cyc(); pulses += done; end
        total++; if ({min_o, sec_o, pwr_led} !== {7'd0, 6'd2, 3'b010}) begin bad++; $display("FAIL cd_early got=%0d:%0d led=%b exp=0:2 led=010", min_o, sec_o, pwr_led); end
        cyc(); pulses += done;
        total++; if ({state_o, min_o, sec_o} !== {2'd1, 7'd0, 6'd1}) begin bad++; $display("FAIL cd_first_tick got=st%0d %0d:%0d exp=st1 0:1", state_o, min_o, sec_o); end
        repeat (4) begin cyc(); pulses += done; end
        total++; if ({state_o, min_o, sec_o, done} !== {2'd3, 13'd0, 1'b1}) begin bad++; $display("FAIL cd_done got=st%0d %0d:%0d d=%b exp=st3 0:0 d=1", state_o, min_o, sec_o, done); end
        repeat (2) begin cyc(); pulses += done; end
        total++; if ({state_o, pwr_led, done} !== {2'd3, 3'd0, 1'b0}) begin bad++; $display("FAIL cd_after got=st%0d led=%b d=%b exp=st3 led=000 d=0", state_o, pwr_led, done); end
        total++; if (pulses != 1) begin bad++; $display("FAIL cd_pulses got=%0d exp=1", pulses); end
        inc = 1; cyc(); inc = 0;
        total++; if ({state_o, min_o, sec_o} !== {2'd0, 13'd0}) begin bad++; $display("FAIL cd_exit got=st%0d %0d:%0d exp=st0 0:0", state_o, min_o, sec_o); end
    endtask

    task automatic test_pause();
        step = 1; inc = 1; cyc(); inc = 0;
        start = 1; cyc(); start = 0;
        repeat (5) cyc();
        pause = 1; cyc(); pause = 0;
        total++; if ({state_o, min_o, sec_o} !== {2'd2, 7'd0, 6'd9}) begin bad++; $display("FAIL pause_enter got=st%0d %0d:%0d exp=st2 0:9", state_o, min_o, sec_o); end
        repeat (10) cyc();
        total++; if ({state_o, sec_o, pwr_led} !== {2'd2, 6'd9, 3'd0}) begin bad++; $display("FAIL pause_hold got=st%0d s%0d led=%b exp=st2 s9 led=000", state_o, sec_o, pwr_led); end
        door = 1; start = 1; cyc(); start = 0;
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL pause_door got=%0d exp=2", state_o); end
        door = 0; cyc();
        start = 1; cyc(); start = 0;
        total++; if ({state_o, sec_o} !== {2'd1, 6'd9}) begin bad++; $display("FAIL pause_resume got=st%0d s%0d exp=st1 s9", state_o, sec_o); end
        cyc();
        total++; if (sec_o !== 6'd9) begin bad++; $display("FAIL resume_phase1 got=%0d exp=9", sec_o); end
        cyc();
        total++; if (sec_o !== 6'd8) begin bad++; $display("FAIL resume_phase2 got=%0d exp=8", sec_o); end
        stop = 1; cyc(); stop = 0;
    endtask

    task automatic test_presets();
        preset = 2; cyc();
        total++; if ({min_o, sec_o, pwr_o} !== {7'd3, 6'd30, 2'd2}) begin bad++; $display("FAIL preset2 got=%0d:%0d p%0d exp=3:30 p2", min_o, sec_o, pwr_o); end
        step = 2; inc = 1; cyc(); inc = 0;
        total++; if ({min_o, sec_o} !== {7'd3, 6'd30}) begin bad++; $display("FAIL preset_inc got=%0d:%0d exp=3:30", min_o, sec_o); end
        preset = 5; cyc();
        total++; if ({min_o, sec_o, pwr_o} !== {7'd3, 6'd30, 2'd2}) begin bad++; $display("FAIL preset5 got=%0d:%0d p%0d exp=3:30 p2", min_o, sec_o, pwr_o); end
        step = 0; inc = 1; cyc(); inc = 0;
        total++; if ({min_o, sec_o} !== {7'd3, 6'd31}) begin bad++; $display("FAIL preset_manual got=%0d:%0d exp=3:31", min_o, sec_o); end
        preset = 3; cyc(); preset = 7; cyc();
        total++; if ({min_o, sec_o, pwr_o} !== {7'd1, 6'd15, 2'd3}) begin bad++; $display("FAIL preset3_keep got=%0d:%0d p%0d exp=1:15 p3", min_o, sec_o, pwr_o); end
        stop = 1; cyc(); stop = 0;
        total++; if ({min_o, sec_o, pwr_o} !== {13'd0, 2'd2}) begin bad++; $display("FAIL preset_stop got=%0d:%0d p%0d exp=0:0 p2", min_o, sec_o, pwr_o); end
        preset = 1; cyc();
        total++; if ({min_o, sec_o, pwr_o} !== {7'd99, 6'd30, 2'd1}) begin bad++; $display("FAIL preset1 got=%0d:%0d p%0d exp=99:30 p1", min_o, sec_o, pwr_o); end
        preset = 0; stop = 1; cyc(); stop = 0;
    endtask

    task automatic test_priority();
        int seen = 0;
        step = 0; inc = 1; repeat (5) cyc(); inc = 0;
        start = 1; cyc(); start = 0;
        repeat (2) cyc();
        stop = 1; door = 1; cyc(); stop = 0;
        total++; if ({state_o, min_o, sec_o} !== {2'd0, 13'd0}) begin bad++; $display("FAIL stop_door got=st%0d %0d:%0d exp=st0 0:0", state_o, min_o, sec_o); end
        door = 0; cyc();
        inc = 1; cyc(); inc = 0;
        start = 1; cyc(); start = 0;
        repeat (2) cyc();
        reset = 1;
        #1;
        total++; if ({state_o, min_o, sec_o, pwr_o, pwr_led, done} !== {2'd0, 13'd0, 2'd2, 3'd0, 1'b0}) begin
            bad++; $display("FAIL reset_mid got=st%0d %0d:%0d p%0d led=%b d=%b exp=st0 0:0 p2 000 0", state_o, min_o, sec_o, pwr_o, pwr_led, done);
        end
        repeat (6) begin @(posedge clock); #1; seen += done; end
        reset = 0;
        m_reset();
        total++; if (seen != 0 || state_o !== 2'd0) begin bad++; $display("FAIL reset_no_done got=%0d pulses st%0d exp=0 pulses st0", seen, state_o); end
    endtask

    task automatic test_quick();
        preset = 0; door = 0;
        start = 1; cyc(); start = 0;
        total++; if ({state_o, min_o, sec_o} !== {2'(QS ? 1 : 0), 7'd0, 6'(QS ? 30 : 0)}) begin
            bad++; $display("FAIL quick_start got=st%0d %0d:%0d exp=st%0d 0:%0d", state_o, min_o, sec_o, QS, QS ? 30 : 0);
        end
        start = 1; cyc(); start = 0;
        total++; if ({state_o, min_o, sec_o} !== {2'(QS ? 1 : 0), 7'(QS ? 1 : 0), 6'd0}) begin
            bad++; $display("FAIL quick_add got=st%0d %0d:%0d exp=st%0d %0d:0", state_o, min_o, sec_o, QS, QS ? 1 : 0);
        end
        stop = 1; cyc(); stop = 0;
    endtask

    task automatic test_random();
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            stop  = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 15) == 0);
            inc   = ($urandom_range(0, 3) == 0);
            dec   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 31) == 0) door = ~door;
            step    = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            pwr_sel = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) preset = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'd0;
            cyc();
            total++;
            if ({state_o, min_o, sec_o, pwr_o, pwr_led, done} !==
                {2'(m_st), 7'(m_t / 60), 6'(m_t % 60), 2'(m_pwr), 3'(m_led), m_done}) begin
                bad++;
                $display("FAIL random cyc=%0d got st%0d %0d:%0d p%0d led=%b d=%b exp st%0d %0d:%0d p%0d led=%b d=%b",
                         i, state_o, min_o, sec_o, pwr_o, pwr_led, done, m_st, m_t / 60, m_t % 60, m_pwr, 3'(m_led), m_done);
            end
        end
        {stop, start, pause, inc, dec, door, pwr_sel} = '0;
        preset = 0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_countdown();
        test_pause();
        test_presets();
        test_priority();
        test_quick();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cook_ctrl_param.md
Name: cook_ctrl_param

Overview:
- Parametrised successor to the board's microwave controller.
- Owns the config/cook/pause/done state machine, time entry (min:sec with carry/borrow and saturation), power level, a preset table and the internal seconds countdown.
- Sits between the button/switch conditioning logic (debounce + edge detect, external) and the display driver / power LEDs.
- All button inputs are one-cycle synchronous pulses.

Parameters:
- TICK_DIV, 100_000_000: clock cycles per countdown second (benches use 4).
- MAX_MIN, 99: maximum minutes value; the time field saturates at MAX_MIN:59.
- N_PWR, 3: number of power levels (1..N_PWR), minimum 2.
- DEF_PWR, 2: power level after reset and after stop.
- NUM_PRESETS, 3: active preset entries (1..7) taken from the package table.

Ports:
- clock  in  1  system clock
- reset  in  1  reset; asynchronous, active-high
- start  in  1  pulse: start / resume
- stop  in  1  pulse: abort and clear
- pause  in  1  pulse: toggle cook/pause
- door  in  1  level: 1 = door open
- inc  in  1  pulse: increment time or power
- dec  in  1  pulse: decrement time or power
- pwr_sel  in  1  level: 1 = inc/dec act on power, 0 = on time
- step  in  2  time step: 0 = 1 s, 1 = 10 s, 2 = 1 min, 3 = 10 min
- preset  in  3  0 = manual; 1..NUM_PRESETS = preset; higher values are treated as 0
- min_o  out  clog2(MAX_MIN+1)  minutes shown
- sec_o  out  6  seconds shown (0..59)
- pwr_o  out  clog2(N_PWR+1)  current power level
- pwr_led  out  N_PWR  one-hot power level; zero outside COOK
- state_o  out  2  0 = IDLE, 1 = COOK, 2 = PAUSED, 3 = DONE
- done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset values: state IDLE; time 0:00; pwr_o = DEF_PWR; pwr_led = 0; done = 0; prescaler = 0. All outputs are registered.
- Event priority each cycle: stop > door > tick > start/pause > inc/dec.
- IDLE:
  - Preset valid: load minutes, seconds and power from the table every cycle; inc/dec ignored.
  - Manual: inc/dec apply to power when pwr_sel = 1, otherwise to time.
  - start with door = 0 and time != 0:00 -> COOK; prescaler cleared.
  - start with time = 0:00 is ignored.
  - stop -> time cleared to 0:00, power reset to DEF_PWR.
- Time arithmetic (total seconds):
  - inc: t = min(t + step_s, MAX_MIN*60 + 59).
  - dec: t = max(t - step_s, 0).
  - Carry and borrow between seconds and minutes are exact (e.g. 0:55 + 10 s = 1:05).
- Power: inc/dec change the level by 1, saturating at 1 and N_PWR.
- COOK:
  - Prescaler counts 0..TICK_DIV-1; a tick on wrap decrements time by 1 s.
  - Tick with time = 0:01 -> time 0:00, state DONE, done = 1 for the next cycle only.
  - door = 1 or pause -> PAUSED.
  - stop -> IDLE, time cleared.
  - inc/dec ignored.
  - pwr_led = one-hot of (pwr_o - 1), registered, so it updates one cycle after state changes.
- PAUSED:
  - Prescaler holds its value, so resume keeps the sub-second phase.
  - start or pause with door = 0 -> COOK. Either input is ignored while door = 1.
  - stop -> IDLE, time cleared.
- DONE:
  - Time stays 0:00.
  - Any of start, stop, pause, inc or dec, or a door rising edge -> IDLE.
  - A start in DONE does not restart cooking.
- Reset mid-cook: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro: COOK_CTRL_QUICK_START_EN.
- Defined: start in IDLE with time 0:00, preset 0 and door = 0 loads 0:30 and enters COOK on the same edge. A start in COOK adds 30 s, saturating at MAX_MIN:59.
- Undefined: both cases are ignored, as described above.

Decomposition:
- Package cook_ctrl_pkg holds:
  - state encoding constants (ST_IDLE, ST_COOK, ST_PAUSED, ST_DONE);
  - step-to-seconds constants;
  - the preset table as 7 entries of {min, sec, pwr}: 1 = 99:30 pwr 1, 2 = 3:30 pwr 2, 3 = 1:15 pwr 3, 4..7 = 0:00 pwr DEF_PWR;
  - the quick-start increment (30 s).
- One sub-module: cook_tick_gen (prescaler with run/hold/clear inputs, tick output).

Test Plan:
- (TICK_DIV = 4 for all scenarios.)
- Manual set: step = 1, inc x6 from 0:00 -> 1:00; step = 0, dec x1 -> 0:59; step = 3, inc x20 -> 99:59 (saturated); dec at 0:00 -> stays 0:00.
- Countdown: 0:02, start -> COOK; time 0:01 after 4 cycles, 0:00 after 8; state DONE and a single done pulse; pwr_led = 0 after DONE.
- Pause/door: cook 0:10; pause after 6 cycles -> PAUSED, prescaler frozen; start while door = 1 -> still PAUSED; door = 0 then start -> COOK; next tick arrives 2 cycles later.
- Presets: preset = 2 -> 3:30, pwr 2; inc ignored; preset = 5 -> manual mode, retaining 3:30; stop -> 0:00, pwr DEF_PWR.
- Priority: stop and door asserted on the same cycle in COOK -> IDLE, time 0:00. Reset asserted mid-COOK -> all reset values, no done pulse.
- Quick start (macro defined): start at 0:00 -> COOK at 0:30; start again -> 1:00. With the macro undefined, the same stimulus stays IDLE at 0:00.
